// File: rtl/control.sv
// Multi-cycle main control FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK, four cycles per instruction.
// Outputs are registered: each edge loads the strobes for the state being left, so they trail state by one cycle.
module control #(
  parameter int                    PC_WIDTH = 13,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          Opcode,
  output logic [PC_WIDTH-1:0] PC,
  output logic                InstructionTypeSelect,
  output logic [2:0]          ALU_Op,
  output logic                WriteFlag,
  output logic                ReadFlag,
  output logic                instructionControl
);

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          opcode_reg, opcode_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [2:0]          alu_reg, alu_next;
  logic                its_reg, its_next;
  logic                wr_reg, wr_next;
  logic                rd_reg, rd_next;
  logic                ic_reg, ic_next;

  logic [2:0]          dec_alu;
  logic                dec_its;
  logic                dec_wr;

  // Decode of the opcode latched during DECODE; branches (10x) never write back.
  always_comb begin
    dec_alu = 3'b000;
    dec_its = 1'b0;
    dec_wr  = 1'b1;
    case (opcode_reg)
      3'b000: dec_alu = 3'b000;
      3'b001: dec_alu = 3'b001;
      3'b010: begin dec_alu = 3'b000; dec_its = 1'b1; end
      3'b011: begin dec_alu = 3'b001; dec_its = 1'b1; end
      3'b100,
      3'b101: begin dec_alu = 3'b010; dec_wr = 1'b0; end
      3'b110: dec_alu = 3'b100;
      3'b111: dec_alu = 3'b101;
      default: dec_alu = 3'b000;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    opcode_next = opcode_reg;
    pc_next     = pc_reg;
    alu_next    = alu_reg;
    its_next    = its_reg;
    wr_next     = 1'b0;
    rd_next     = 1'b0;
    ic_next     = 1'b0;
    case (state_reg)
      FETCH: begin
        state_next = DECODE;
        rd_next    = 1'b1;
        ic_next    = 1'b1;
      end
      DECODE: begin
        state_next  = EXECUTE;
        opcode_next = Opcode;
      end
      EXECUTE: begin
        state_next = WRITEBACK;
        alu_next   = dec_alu;
        its_next   = dec_its;
      end
      WRITEBACK: begin
        state_next = FETCH;
        wr_next    = dec_wr;
        pc_next    = pc_reg + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= FETCH;
      opcode_reg <= 3'b000;
      pc_reg     <= RESET_PC;
      alu_reg    <= 3'b000;
      its_reg    <= 1'b0;
      wr_reg     <= 1'b0;
      rd_reg     <= 1'b0;
      ic_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      opcode_reg <= opcode_next;
      pc_reg     <= pc_next;
      alu_reg    <= alu_next;
      its_reg    <= its_next;
      wr_reg     <= wr_next;
      rd_reg     <= rd_next;
      ic_reg     <= ic_next;
    end
  end

  assign PC                    = pc_reg;
  assign InstructionTypeSelect = its_reg;
  assign ALU_Op                = alu_reg;
  assign WriteFlag             = wr_reg;
  assign ReadFlag              = rd_reg;
  assign instructionControl    = ic_reg;

endmodule

// File: tb/tb_control.sv
// Directed bench for control: per-cycle expected outputs are queued per instruction and popped
// on each falling edge for comparison.
module tb_control;

  typedef struct packed {
    logic [12:0] pc;
    logic        its;
    logic [2:0]  alu;
    logic        wr;
    logic        rd;
    logic        ic;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  Opcode;
  logic [12:0] PC;
  logic        InstructionTypeSelect;
  logic [2:0]  ALU_Op;
  logic        WriteFlag;
  logic        ReadFlag;
  logic        instructionControl;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [12:0] pc_m;
  logic [2:0]  alu_m;
  logic        its_m;

  control #(.PC_WIDTH(13), .RESET_PC(13'd0)) dut (
    .clk                  (clk),
    .reset                (reset),
    .Opcode               (Opcode),
    .PC                   (PC),
    .InstructionTypeSelect(InstructionTypeSelect),
    .ALU_Op               (ALU_Op),
    .WriteFlag            (WriteFlag),
    .ReadFlag             (ReadFlag),
    .instructionControl   (instructionControl)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_alu(input logic [2:0] op);
    case (op)
      3'b000, 3'b010: return 3'b000;
      3'b001, 3'b011: return 3'b001;
      3'b100, 3'b101: return 3'b010;
      3'b110:         return 3'b100;
      default:        return 3'b101;
    endcase
  endfunction

  function automatic logic ref_its(input logic [2:0] op);
    return (op == 3'b010) || (op == 3'b011);
  endfunction

  function automatic logic ref_wr(input logic [2:0] op);
    return op[2:1] != 2'b10;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.pc  = PC;
    o.its = InstructionTypeSelect;
    o.alu = ALU_Op;
    o.wr  = WriteFlag;
    o.rd  = ReadFlag;
    o.ic  = instructionControl;
    return o;
  endfunction

  function automatic exp_t mk(input logic [12:0] pc, input logic its, input logic [2:0] alu,
                              input logic wr, input logic rd, input logic ic);
    exp_t e;
    e.pc = pc; e.its = its; e.alu = alu; e.wr = wr; e.rd = rd; e.ic = ic;
    return e;
  endfunction

  // Pops the oldest expectation and compares it with the current outputs.
  task automatic compare(input string tag);
    exp_t e;
    exp_t o;
    o = observed();
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s: scoreboard empty, got %h", tag, o);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: got pc=%0d its=%b alu=%b wr=%b rd=%b ic=%b, expected pc=%0d its=%b alu=%b wr=%b rd=%b ic=%b",
               tag, o.pc, o.its, o.alu, o.wr, o.rd, o.ic, e.pc, e.its, e.alu, e.wr, e.rd, e.ic);
      end
    end
    checks++;
    assert (!(ReadFlag === 1'b1 && WriteFlag === 1'b1)) else begin
      errors++;
      $error("FAIL %s_strobe_excl: got rd=%b wr=%b, expected not both 1", tag, ReadFlag, WriteFlag);
    end
  endtask

  // Runs one full instruction; alt is driven on Opcode once DECODE has sampled, and must be ignored.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] alt);
    logic [2:0]  na;
    logic        ni;
    logic [12:0] start_pc;
    na = ref_alu(op);
    ni = ref_its(op);
    start_pc = pc_m;
    Opcode = op;
    exp_q.push_back(mk(pc_m, its_m, alu_m, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(pc_m, its_m, alu_m, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(pc_m, ni, na, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(pc_m + 13'd1, ni, na, ref_wr(op), 1'b0, 1'b0));
    pc_m  = pc_m + 13'd1;
    alu_m = na;
    its_m = ni;
    @(negedge clk); compare("fetch");
    @(negedge clk); compare("decode");
    Opcode = alt;
    @(negedge clk); compare("execute");
    @(negedge clk); compare("writeback");
    $display("instr op=%b alt=%b pc=%0d alu=%b its=%b wr=%b", op, alt, start_pc, na, ni, ref_wr(op));
  endtask

  initial begin
    reset  = 1'b0;
    Opcode = 3'b000;
    pc_m   = 13'd0;
    alu_m  = 3'b000;
    its_m  = 1'b0;

    // Reset held for two cycles.
    exp_q.push_back(mk(13'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(13'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    @(negedge clk); compare("reset_c1");
    @(negedge clk); compare("reset_c2");
    reset = 1'b1;

    run_instr(3'b000, 3'b000);
    run_instr(3'b000, 3'b000);
    run_instr(3'b001, 3'b001);
    run_instr(3'b001, 3'b001);
    run_instr(3'b010, 3'b010);
    run_instr(3'b011, 3'b011);
    run_instr(3'b100, 3'b100);
    run_instr(3'b100, 3'b100);
    run_instr(3'b100, 3'b100);
    run_instr(3'b110, 3'b110);
    run_instr(3'b111, 3'b111);
    // Opcode changed after DECODE must not affect the running instruction.
    run_instr(3'b000, 3'b111);
    run_instr(3'b011, 3'b100);
    run_instr(3'b101, 3'b010);

    // Reset asserted while in WRITEBACK: outputs clear at once, PC returns to 0.
    Opcode = 3'b001;
    exp_q.push_back(mk(pc_m, its_m, alu_m, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(mk(pc_m, its_m, alu_m, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(pc_m, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0));
    @(negedge clk); compare("wbrst_fetch");
    @(negedge clk); compare("wbrst_decode");
    @(negedge clk); compare("wbrst_execute");
    reset = 1'b0;
    pc_m  = 13'd0;
    alu_m = 3'b000;
    its_m = 1'b0;
    #1;
    exp_q.push_back(mk(13'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    compare("wbrst_async");
    exp_q.push_back(mk(13'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
    @(negedge clk); compare("wbrst_held");
    reset = 1'b1;
    $display("instr reset during writeback, pc=0");
    run_instr(3'b001, 3'b001);

    // Free-run add instructions up to PC=8191, then check the wrap.
    Opcode = 3'b000;
    repeat ((8191 - int'(pc_m)) * 4) @(negedge clk);
    pc_m  = 13'd8191;
    alu_m = 3'b000;
    its_m = 1'b0;
    run_instr(3'b010, 3'b010);
    run_instr(3'b110, 3'b110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
